dodge_game_core: RTL and testbench

- Parametrised falling-object dodge-game engine for the LED-matrix board.
- Drives a row-scanned ROWS x COLS matrix.
- Owns the game state machine, the player position, a pool of falling-object slots, collision detection, score and lives.
- The pseudo-random column source is external (LFSR block). Buttons arrive already debounced.

---
 rtl/dodge_game_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_dodge_game_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dodge_game_core.sv
// Falling-object dodge game engine: player, object slots, collisions, score and lives,
// rendered onto a row-scanned LED matrix one row per clock.
module dodge_game_core #(
    parameter int ROWS      = 16,
    parameter int COLS      = 32,
    parameter int SLOTS     = 8,
    parameter int TICK      = 250,
    parameter int OBJ_LEN   = 3,
    parameter int PLAYER_W  = 5,
    parameter int PLAYER_H  = 2,
    parameter int LIVES     = 3,
    parameter int HIT_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    left_btn,
    input  logic                    right_btn,
    input  logic                    function_btn,
    input  logic [1:0]              level,
    input  logic [$clog2(COLS)-1:0] rnd,
    output logic [ROWS-1:0]         screen_row,
    output logic [COLS-1:0]         screen_col,
    output logic [1:0]              state,
    output logic [15:0]             score,
    output logic [3:0]              lives,
    output logic                    game_over
);
    localparam int CW = $clog2(COLS);
    localparam int HW = $clog2(ROWS + OBJ_LEN);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(TICK + 1);
    localparam int XW = $clog2(HIT_TICKS + 1);
    localparam int NW = $clog2(SLOTS + 1);

    localparam logic [CW-1:0]   PMAX     = CW'(COLS - PLAYER_W);
    localparam logic [CW-1:0]   PCENTER  = CW'((COLS - PLAYER_W) / 2);
    localparam logic [HW-1:0]   HEAD_END = HW'(ROWS + OBJ_LEN - 1);
    localparam logic [HW-1:0]   PTOP     = HW'(ROWS - PLAYER_H);
    localparam logic [COLS-1:0] PMASK0   = {{(COLS - PLAYER_W){1'b0}}, {PLAYER_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] row_q, row_d;
    logic [RW-1:0]   ridx_q, ridx_d;
    logic [COLS-1:0] col_q, col_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [CW-1:0]   ocol_q [SLOTS];
    logic [CW-1:0]   ocol_d [SLOTS];
    logic [HW-1:0]   head_q [SLOTS];
    logic [HW-1:0]   head_d [SLOTS];
    logic [CW-1:0]   pcol_q, pcol_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [1:0]      scnt_q, scnt_d;
    logic [XW-1:0]   hcnt_q, hcnt_d;
    logic [15:0]     score_q, score_d;
    logic [3:0]      lives_q, lives_d;
    logic            btn_q;

    logic            fn_edge;
    logic            tick;
    logic [SLOTS-1:0] alive;
    logic [SLOTS-1:0] hitv;
    logic [NW-1:0]   nret;
    logic            found;
    logic [CW-1:0]   pend;
    logic [16:0]     ssum;
    logic [COLS-1:0] objrow;
    logic [COLS-1:0] pmask;
    logic            showp;
    logic            prow;

    assign fn_edge = function_btn & ~btn_q;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ocol_d  = ocol_q;
        head_d  = head_q;
        pcol_d  = pcol_q;
        tcnt_d  = tcnt_q;
        scnt_d  = scnt_q;
        hcnt_d  = hcnt_q;
        score_d = score_q;
        lives_d = lives_q;
        tick    = 1'b0;
        alive   = '0;
        hitv    = '0;
        nret    = '0;
        found   = 1'b0;
        pend    = '0;
        ssum    = '0;

        case (state_q)
            ST_IDLE: begin
                if (fn_edge) begin
                    state_d = ST_PLAY;
                    valid_d = '0;
                    score_d = '0;
                    lives_d = 4'(LIVES);
                    pcol_d  = PCENTER;
                    tcnt_d  = '0;
                    scnt_d  = '0;
                    hcnt_d  = '0;
                end
            end
            ST_OVER: begin
                if (fn_edge) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (tcnt_q == TW'(TICK - 1)) begin
                    tcnt_d = '0;
                    tick   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
        endcase

        // One game tick: move, fall, retire, collide, then spawn into the freed pool.
        if (tick) begin
            if (right_btn && !left_btn && pcol_q != PMAX) begin
                pcol_d = pcol_q + CW'(1);
            end else if (left_btn && !right_btn && pcol_q != '0) begin
                pcol_d = pcol_q - CW'(1);
            end
            pend = pcol_d + CW'(PLAYER_W - 1);

            for (int i = 0; i < SLOTS; i++) begin
                if (valid_q[i]) begin
                    head_d[i] = head_q[i] + HW'(1);
                    if (head_d[i] == HEAD_END) begin
                        nret = nret + NW'(1);
                    end else begin
                        alive[i] = 1'b1;
                        if (state_q == ST_PLAY && head_d[i] >= PTOP &&
                            ocol_q[i] >= pcol_d && ocol_q[i] <= pend) begin
                            hitv[i] = 1'b1;
                        end
                    end
                end
            end
            valid_d = alive & ~hitv;

            ssum    = {1'b0, score_q} + 17'(nret);
            score_d = ssum[16] ? 16'hFFFF : ssum[15:0];

            if (|hitv) begin
                if (lives_q > 4'd1) begin
                    lives_d = lives_q - 4'd1;
                    state_d = ST_HIT;
                    hcnt_d  = '0;
                end else begin
                    lives_d = '0;
                    state_d = ST_OVER;
                end
            end

            if (state_q == ST_HIT) begin
                hcnt_d = hcnt_q + XW'(1);
                if (hcnt_d == XW'(HIT_TICKS)) begin
                    state_d = ST_PLAY;
                end
            end

            if (scnt_q >= 2'd3 - level) begin
                scnt_d = '0;
                for (int i = 0; i < SLOTS; i++) begin
                    if (!found && !valid_d[i]) begin
                        valid_d[i] = 1'b1;
                        ocol_d[i]  = rnd;
                        head_d[i]  = '0;
                        found      = 1'b1;
                    end
                end
            end else begin
                scnt_d = scnt_q + 2'd1;
            end
        end
    end

    // Column data is built for the row that becomes active on this edge.
    always_comb begin
        ridx_d = (ridx_q == RW'(ROWS - 1)) ? '0 : ridx_q + RW'(1);
        row_d  = {row_q[ROWS-2:0], row_q[ROWS-1]};
        objrow = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_q[i] && int'(head_q[i]) >= int'(ridx_d) &&
                int'(head_q[i]) <= int'(ridx_d) + OBJ_LEN - 1) begin
                objrow[ocol_q[i]] = 1'b1;
            end
        end
        pmask = PMASK0 << pcol_q;
        showp = (state_q == ST_PLAY) || (state_q == ST_HIT && !hcnt_q[0]);
        prow  = int'(ridx_d) >= ROWS - PLAYER_H;

        case (state_q)
            ST_IDLE: col_d = '1;
            ST_OVER: col_d = (int'(ridx_d) < ROWS / 2) ? '1 : '0;
            default: col_d = objrow | ((prow && showp) ? pmask : '0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= ROWS'(1);
            ridx_q  <= '0;
            col_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                ocol_q[i] <= '0;
                head_q[i] <= '0;
            end
            pcol_q  <= PCENTER;
            tcnt_q  <= '0;
            scnt_q  <= '0;
            hcnt_q  <= '0;
            score_q <= '0;
            lives_q <= 4'(LIVES);
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            ridx_q  <= ridx_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            ocol_q  <= ocol_d;
            head_q  <= head_d;
            pcol_q  <= pcol_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            btn_q   <= function_btn;
        end
    end

    assign screen_row = row_q;
    assign screen_col = col_q;
    assign state      = state_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_dodge_game_core.sv
// Bench for dodge_game_core: a queue-based game model predicts every registered output
// per cycle; a monitor pops those predictions and compares them with the DUT.
module tb_dodge_game_core;
    localparam int ROWS      = 16;
    localparam int COLS      = 32;
    localparam int SLOTS     = 8;
    localparam int TICK      = 4;
    localparam int OBJ_LEN   = 3;
    localparam int PLAYER_W  = 5;
    localparam int PLAYER_H  = 2;
    localparam int LIVES     = 3;
    localparam int HIT_TICKS = 8;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            leftBtn = 1'b0;
    logic            rightBtn = 1'b0;
    logic            fnBtn = 1'b0;
    logic [1:0]      level = 2'd0;
    logic [4:0]      rnd = 5'd0;
    logic [ROWS-1:0] screenRow;
    logic [COLS-1:0] screenCol;
    logic [1:0]      stateOut;
    logic [15:0]     scoreOut;
    logic [3:0]      livesOut;
    logic            gameOver;

    dodge_game_core #(
        .ROWS(ROWS), .COLS(COLS), .SLOTS(SLOTS), .TICK(TICK), .OBJ_LEN(OBJ_LEN),
        .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H), .LIVES(LIVES), .HIT_TICKS(HIT_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rstN),
        .left_btn(leftBtn),
        .right_btn(rightBtn),
        .function_btn(fnBtn),
        .level(level),
        .rnd(rnd),
        .screen_row(screenRow),
        .screen_col(screenCol),
        .state(stateOut),
        .score(scoreOut),
        .lives(livesOut),
        .game_over(gameOver)
    );

    always #5 clk = ~clk;

    typedef struct { int col; int head; } obj_t;
    typedef struct {
        logic [ROWS-1:0] row;
        logic [COLS-1:0] col;
        logic [1:0]      st;
        logic [15:0]     score;
        logic [3:0]      lives;
        logic            go;
    } exp_t;

    exp_t expQ[$];
    obj_t objs[$];
    int   mState = 0;
    int   mScore = 0;
    int   mLives = LIVES;
    int   mPcol  = (COLS - PLAYER_W) / 2;
    int   mTick  = 0;
    int   mSpawn = 0;
    int   mHit   = 0;
    int   mRow   = 0;
    bit   mBtn   = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   cycle  = 0;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cycle, got, want);
        end
    endtask

    // Matrix content for row r as a player would see it, from the model's current game.
    function automatic logic [COLS-1:0] expectedCols(input int r);
        logic [COLS-1:0] v;
        v = '0;
        if (mState == 0) return '1;
        if (mState == 3) return (r < ROWS / 2) ? '1 : '0;
        foreach (objs[k]) begin
            if (r <= objs[k].head && r >= objs[k].head - OBJ_LEN + 1) v[objs[k].col] = 1'b1;
        end
        if (r >= ROWS - PLAYER_H && (mState == 1 || (mState == 2 && mHit % 2 == 0))) begin
            for (int c = mPcol; c < mPcol + PLAYER_W; c++) v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic startGame();
        objs.delete();
        mState = 1;
        mScore = 0;
        mLives = LIVES;
        mPcol  = (COLS - PLAYER_W) / 2;
        mTick  = 0;
        mSpawn = 0;
        mHit   = 0;
    endtask

    task automatic gameStep();
        bit   edgeSeen;
        int   st0;
        int   retired;
        int   hits;
        int   h;
        obj_t keep[$];
        edgeSeen = fnBtn && !mBtn;
        mBtn = fnBtn;
        st0 = mState;
        if (st0 == 0) begin
            if (edgeSeen) startGame();
        end else if (st0 == 3) begin
            if (edgeSeen) mState = 0;
        end else if (mTick < TICK - 1) begin
            mTick++;
        end else begin
            mTick = 0;
            if (rightBtn && !leftBtn && mPcol < COLS - PLAYER_W) mPcol++;
            if (leftBtn && !rightBtn && mPcol > 0) mPcol--;
            retired = 0;
            hits = 0;
            foreach (objs[k]) begin
                h = objs[k].head + 1;
                if (h == ROWS + OBJ_LEN - 1) retired++;
                else if (st0 == 1 && h >= ROWS - PLAYER_H &&
                         objs[k].col >= mPcol && objs[k].col < mPcol + PLAYER_W) hits++;
                else keep.push_back('{col: objs[k].col, head: h});
            end
            objs = keep;
            mScore = (mScore + retired > 65535) ? 65535 : mScore + retired;
            if (hits > 0) begin
                if (mLives > 1) begin
                    mLives--;
                    mState = 2;
                    mHit = 0;
                end else begin
                    mLives = 0;
                    mState = 3;
                end
            end
            if (st0 == 2) begin
                mHit++;
                if (mHit == HIT_TICKS) mState = 1;
            end
            if (mSpawn >= 3 - int'(level)) begin
                mSpawn = 0;
                if (objs.size() < SLOTS) objs.push_back('{col: int'(rnd), head: 0});
            end else begin
                mSpawn++;
            end
        end
    endtask

    task automatic applyStimulus(input logic rs, input logic l, input logic r, input logic fn,
                                 input logic [1:0] lv, input logic [4:0] rn);
        exp_t e;
        int   nrow;
        @(negedge clk);
        rstN = rs;
        leftBtn = l;
        rightBtn = r;
        fnBtn = fn;
        level = lv;
        rnd = rn;
        if (!rs) begin
            objs.delete();
            mState = 0;
            mScore = 0;
            mLives = LIVES;
            mPcol  = (COLS - PLAYER_W) / 2;
            mTick  = 0;
            mSpawn = 0;
            mHit   = 0;
            mBtn   = 1'b0;
            mRow   = 0;
            e.row  = ROWS'(1);
            e.col  = '0;
        end else begin
            nrow  = (mRow + 1) % ROWS;
            e.col = expectedCols(nrow);
            e.row = ROWS'(1) << nrow;
            mRow  = nrow;
            gameStep();
        end
        e.st    = 2'(mState);
        e.score = 16'(mScore);
        e.lives = 4'(mLives);
        e.go    = (mState == 3);
        expQ.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("screen_row", 64'(screenRow), 64'(e.row));
                checkOutput("screen_col", 64'(screenCol), 64'(e.col));
                checkOutput("state", 64'(stateOut), 64'(e.st));
                checkOutput("score", 64'(scoreOut), 64'(e.score));
                checkOutput("lives", 64'(livesOut), 64'(e.lives));
                checkOutput("game_over", 64'(gameOver), 64'(e.go));
            end
        end
    end

    initial begin
        logic       l;
        logic       r;
        logic       fn;
        logic       rs;
        logic [1:0] lv;
        l = 1'b0;
        r = 1'b0;
        lv = 2'd3;

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd2);
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd2);

        // Fill the pool at column 2, then sweep the player to both edges and hold both buttons.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd2);
        repeat (120) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd2);
        repeat (120) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 5'd2);
        repeat (120) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 5'd2);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 5'd2);

        // Objects aimed at the centred player until the game is lost, then restart.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd15);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd15);
        repeat (500) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd15);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd15);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd15);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 5'd15);
        repeat (30) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'(($urandom_range(0, COLS - 1))));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5'd4);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 5'd4);

        for (int n = 0; n < 3000; n++) begin
            if (n % 16 == 0) begin
                l = ($urandom_range(0, 2) == 0);
                r = ($urandom_range(0, 2) == 0);
            end
            if (n % 200 == 0) lv = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 79) == 0);
            rs = ($urandom_range(0, 1499) != 0);
            applyStimulus(rs, l, r, fn, lv, 5'($urandom_range(0, COLS - 1)));
        end

        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
